// File: rtl/ats21_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ats21_pkg
// Description : Shared constants, event record type and lowest-set-bit
//               priority encoder for the ATS21 event queue.
// Revision    : 1.0 - initial release
// ============================================================================
package ats21_pkg;

  localparam int NUM_ALARMS = 24;
  localparam int ALARM_ID_W = $clog2(NUM_ALARMS);
  localparam int TS_WIDTH   = 16;

  // One queued event: which alarm fired and when it was enqueued.
  typedef struct packed {
    logic [ALARM_ID_W-1:0] id;
    logic [TS_WIDTH-1:0]   ts;
  } ats21_event_t;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [ALARM_ID_W-1:0] lowest_set_idx(input logic [NUM_ALARMS-1:0] v);
    lowest_set_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set_idx = i[ALARM_ID_W-1:0];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/ats21_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ats21_sync_fifo
// Description : Single-clock show-ahead FIFO. Head word is presented on rdata
//               whenever the FIFO is non-empty and reads as zero when empty.
//               Push while full is accepted only together with a pop.
// Revision    : 1.0 - initial release
// ============================================================================
module ats21_sync_fifo #(
  parameter int WIDTH = 21,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   C_DEPTH    = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   C_FILL_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_fill;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_fill == '0);
  assign full      = (r_fill == C_DEPTH);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign fill      = r_fill;
  assign rdata     = empty ? '0 : r_mem[r_rptr];

  // Storage array; contents are invisible while empty so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves fill as is.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fill <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + C_PTR_ONE;
      if (w_pop_ok)  r_rptr <= r_rptr + C_PTR_ONE;
      if (w_push_ok && !w_pop_ok)      r_fill <= r_fill + C_FILL_ONE;
      else if (w_pop_ok && !w_push_ok) r_fill <= r_fill - C_FILL_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ats21_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : ats21_event_queue
// Description : Turns rising edges on the ATS21 alarm-finished lines into
//               queued {alarm id, timestamp} events with an interrupt and a
//               sticky overflow flag for coalesced (lost) edges.
// Revision    : 1.0 - initial release
// ============================================================================
module ats21_event_queue
  import ats21_pkg::*;
#(
  parameter int NUM_ALARMS = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_ALARMS-1:0]         alarm_in,
  input  logic [NUM_ALARMS-1:0]         mask,
  input  logic                          pop,
  input  logic                          clr_overflow,
  output logic                          evt_valid,
  output logic [$clog2(NUM_ALARMS)-1:0] evt_id,
  output logic [TS_WIDTH-1:0]           evt_ts,
  output logic [NUM_ALARMS-1:0]         pending,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          overflow,
  output logic                          irq
);

  localparam int ID_W  = $clog2(NUM_ALARMS);
  localparam int EVT_W = ID_W + TS_WIDTH;
  localparam logic [NUM_ALARMS-1:0] C_ONE_HOT = NUM_ALARMS'(1);
  localparam logic [TS_WIDTH-1:0]   C_TS_ONE  = TS_WIDTH'(1);

  logic [NUM_ALARMS-1:0] r_alarm_q;
  logic [NUM_ALARMS-1:0] r_pending;
  logic [TS_WIDTH-1:0]   r_ts_cnt;
  logic                  r_overflow;

  logic [NUM_ALARMS-1:0] w_rise;
  logic [NUM_ALARMS-1:0] w_grant;
  logic [ID_W-1:0]       w_grant_idx;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_eff;
  logic                  w_push;
  logic                  w_coalesce;
  logic [EVT_W-1:0]      w_wdata;
  logic [EVT_W-1:0]      w_rdata;

  assign w_rise     = alarm_in & ~r_alarm_q & mask;
  assign w_pop_eff  = pop & ~w_empty;
  // A slot is free if the FIFO is not full or the head leaves this same edge.
  assign w_push     = (|r_pending) & (~w_full | w_pop_eff);
  assign w_grant    = w_push ? (C_ONE_HOT << w_grant_idx) : '0;
  // A new edge on a line that is still waiting merges into it: one edge lost.
  assign w_coalesce = |(w_rise & r_pending);
  // Timestamp is the counter value before this edge, i.e. the enqueue time.
  assign w_wdata    = {w_grant_idx, r_ts_cnt};

  // Arbitration looks only at the registered pending vector, never at rise.
  generate
    if (NUM_ALARMS == ats21_pkg::NUM_ALARMS) begin : g_pkg_enc
      assign w_grant_idx = lowest_set_idx(r_pending);
    end else begin : g_loop_enc
      // Generic lowest-index encoder for non-default alarm counts.
      always_comb begin
        w_grant_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
          if (r_pending[i]) w_grant_idx = i[ID_W-1:0];
        end
      end
    end
  endgenerate

  ats21_sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop_eff),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .fill  (fill)
  );

  assign evt_valid        = ~w_empty;
  assign {evt_id, evt_ts} = w_rdata;
  assign pending          = r_pending;
  assign overflow         = r_overflow;
  assign irq              = ~w_empty | r_overflow;

  // Edge history, pending set/clear, free-running timestamp and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_alarm_q  <= '0;
      r_pending  <= '0;
      r_ts_cnt   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_alarm_q <= alarm_in;
      r_pending <= (r_pending | w_rise) & ~w_grant;
      r_ts_cnt  <= r_ts_cnt + C_TS_ONE;
      if (w_coalesce)        r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ats21_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ats21_event_queue
// Description : Self-checking bench for ats21_event_queue: directed scenarios
//               with literal expectations plus a randomized run compared every
//               cycle against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ats21_event_queue;
  import ats21_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] alarm_in = '0;
  logic [23:0] mask = '1;
  logic        pop = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        evt_valid;
  logic [4:0]  evt_id;
  logic [15:0] evt_ts;
  logic [23:0] pending;
  logic [3:0]  fill;
  logic        overflow;
  logic        irq;

  int total = 0;
  int bad = 0;
  bit cmp_en = 1'b0;
  int ecount = 0;

  // Behavioural model state
  logic [23:0]  m_prev;
  logic [23:0]  m_pend;
  ats21_event_t m_q[$];
  int           m_ts;
  bit           m_ovf;

  ats21_event_queue #(
    .NUM_ALARMS (24),
    .FIFO_DEPTH (8),
    .TS_WIDTH   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .alarm_in     (alarm_in),
    .mask         (mask),
    .pop          (pop),
    .clr_overflow (clr_overflow),
    .evt_valid    (evt_valid),
    .evt_id       (evt_id),
    .evt_ts       (evt_ts),
    .pending      (pending),
    .fill         (fill),
    .overflow     (overflow),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    m_pend = '0;
    m_q.delete();
    m_ts   = 0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using the inputs present now.
  task automatic model_step();
    logic [23:0]  rise;
    bit           popeff, pushok, coal;
    int           gid;
    ats21_event_t e;
    if (!reset) begin
      model_reset();
      return;
    end
    rise   = alarm_in & ~m_prev & mask;
    popeff = pop && (m_q.size() > 0);
    pushok = (m_pend != 0) && ((m_q.size() < 8) || popeff);
    gid    = -1;
    for (int i = 0; i < 24; i++) begin
      if (gid < 0 && m_pend[i]) gid = i;
    end
    coal = ((rise & m_pend) != 0);
    if (popeff) void'(m_q.pop_front());
    if (pushok) begin
      e.id = 5'(gid);
      e.ts = 16'(m_ts);
      m_q.push_back(e);
    end
    m_pend = m_pend | rise;
    if (pushok) m_pend[gid] = 1'b0;
    if (coal) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    m_ts   = (m_ts + 1) % 65536;
    m_prev = alarm_in;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (reset) ecount++;
    #1;
  endtask

  // Compare process: DUT outputs versus the model every cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
      chk("fill",      32'(fill),      32'(m_q.size()));
      chk("evt_id",    32'(evt_id),    (m_q.size() > 0) ? 32'(m_q[0].id) : 32'd0);
      chk("evt_ts",    32'(evt_ts),    (m_q.size() > 0) ? 32'(m_q[0].ts) : 32'd0);
      chk("pending",   32'(pending),   32'(m_pend));
      chk("overflow",  32'(overflow),  32'(m_ovf));
      chk("irq",       32'(irq),       32'((m_q.size() > 0) || m_ovf));
    end
  end

  initial begin
    int det_edge;
    int cnt2;
    model_reset();
    #1 reset = 1'b0;
    cmp_en = 1'b1;
    #2;
    chk("rst_evt_valid", 32'(evt_valid), 32'd0);
    chk("rst_fill",      32'(fill),      32'd0);
    chk("rst_pending",   32'(pending),   32'd0);
    chk("rst_irq",       32'(irq),       32'd0);
    chk("rst_evt_ts",    32'(evt_ts),    32'd0);
    #9 reset = 1'b1;   // released at t=12, first edge at t=15

    // Alarm 5 sampled high at edge 10, held high.
    for (int k = 0; k < 9; k++) tick();
    alarm_in[5] = 1'b1;
    tick();
    chk("s1_pending5", 32'(pending[5]), 32'd1);
    chk("s1_no_evt",   32'(evt_valid),  32'd0);
    tick();
    chk("s1_valid", 32'(evt_valid), 32'd1);
    chk("s1_id",    32'(evt_id),    32'd5);
    chk("s1_ts",    32'(evt_ts),    32'd10);
    for (int k = 0; k < 4; k++) tick();
    chk("s1_single", 32'(fill), 32'd1);
    pop = 1'b1; tick(); pop = 1'b0;

    // Three simultaneous edges drain in index order with consecutive stamps.
    alarm_in[3] = 1'b1; alarm_in[7] = 1'b1; alarm_in[20] = 1'b1;
    tick();
    det_edge = ecount;
    for (int k = 0; k < 3; k++) tick();
    chk("s2_fill", 32'(fill), 32'd3);
    chk("s2_id0", 32'(evt_id), 32'd3);
    chk("s2_ts0", 32'(evt_ts), 32'(det_edge));
    pop = 1'b1; tick(); pop = 1'b0;
    chk("s2_id1", 32'(evt_id), 32'd7);
    chk("s2_ts1", 32'(evt_ts), 32'(det_edge + 1));
    pop = 1'b1; tick(); pop = 1'b0;
    chk("s2_id2", 32'(evt_id), 32'd20);
    chk("s2_ts2", 32'(evt_ts), 32'(det_edge + 2));
    pop = 1'b1; tick(); pop = 1'b0;

    // Fill to 8, then a held-back pending edge enters on a pop.
    alarm_in[17:10] = 8'hFF;
    for (int k = 0; k < 9; k++) tick();
    chk("s3_full", 32'(fill), 32'd8);
    alarm_in[1] = 1'b1; tick(); alarm_in[1] = 1'b0; tick();
    chk("s3_pend1", 32'(pending[1]), 32'd1);
    chk("s3_fill8", 32'(fill), 32'd8);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("s3_fill_same", 32'(fill), 32'd8);
    chk("s3_pend1_gone", 32'(pending[1]), 32'd0);

    // Coalesce on alarm 2 while full.
    alarm_in[2] = 1'b1; tick(); alarm_in[2] = 1'b0; tick();
    alarm_in[2] = 1'b1; tick(); alarm_in[2] = 1'b0;
    chk("s4_ovf", 32'(overflow), 32'd1);
    chk("s4_irq", 32'(irq), 32'd1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("s4_ovf_clr", 32'(overflow), 32'd0);
    cnt2 = 0;
    pop = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (evt_valid && evt_id == 5'd2) cnt2++;
      if (evt_valid) tick();
    end
    pop = 1'b0;
    chk("s4_one_alarm2", 32'(cnt2), 32'd1);
    chk("s4_drained", 32'(fill), 32'd0);

    // Masked line produces nothing; pop on empty is harmless.
    mask[9] = 1'b0;
    alarm_in[9] = 1'b1; tick(); tick(); alarm_in[9] = 1'b0; tick();
    chk("s5_pend9", 32'(pending[9]), 32'd0);
    chk("s5_fill", 32'(fill), 32'd0);
    pop = 1'b1; tick(); pop = 1'b0;
    chk("s5_pop_empty", 32'(fill), 32'd0);
    mask[9] = 1'b1;

    // Queue 4 events, then an asynchronous mid-cycle reset.
    alarm_in[0] = 1'b1; alarm_in[1] = 1'b1; alarm_in[2] = 1'b1; alarm_in[4] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    chk("s6_fill4", 32'(fill), 32'd4);
    #2 reset = 1'b0;
    #1;
    chk("s6_valid0", 32'(evt_valid), 32'd0);
    chk("s6_fill0",  32'(fill),      32'd0);
    chk("s6_pend0",  32'(pending),   32'd0);
    chk("s6_ovf0",   32'(overflow),  32'd0);
    chk("s6_irq0",   32'(irq),       32'd0);
    model_reset();
    tick(); tick();
    reset = 1'b1;
    ecount = 0;

    // Randomized run against the model; phases alternate pop pressure.
    for (int c = 0; c < 2400; c++) begin
      if ($urandom_range(0, 2) == 0) alarm_in = alarm_in ^ (24'd1 << $urandom_range(0, 23));
      if ($urandom_range(0, 5) == 0) alarm_in = alarm_in ^ (24'd1 << $urandom_range(0, 23));
      if ($urandom_range(0, 40) == 0) mask = mask ^ (24'd1 << $urandom_range(0, 23));
      if ((c / 200) % 2 == 0) pop = ($urandom_range(0, 3) != 0);
      else                    pop = ($urandom_range(0, 5) == 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      tick();
    end
    pop = 1'b0;
    clr_overflow = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
